// File: rtl/alu_multicycle.sv
// Registered ALU: ADD/SUB/AND/OR/NOT finish in one cycle; unsigned MUL (shift-add) and DIV (restoring) take one bit per cycle.
// Start/busy/done handshake: start is sampled only in IDLE, and done pulses in FIN with outputs held until the next done.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [2:0]       flag
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic [2:0]       flag_q;

  logic             load;
  logic [WIDTH-1:0] nlo, nhi;
  logic             ovf;

  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH:0]   madd, rsh, rsub;
  logic [WIDTH-1:0] mhi, mlo, dhi, dlo;
  logic             qbit;

  assign sum  = data_a + data_b;
  assign diff = data_a - data_b;

  // MUL: {hi,lo} holds partial product and the remaining multiplier bits, shifted right each step
  assign madd = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign mhi  = madd[WIDTH:1];
  assign mlo  = {madd[0], lo_q[WIDTH-1:1]};

  // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in
  assign rsh  = {hi_q, lo_q[WIDTH-1]};
  assign rsub = rsh - {1'b0, b_q};
  assign qbit = ~rsub[WIDTH];
  assign dhi  = qbit ? rsub[WIDTH-1:0] : rsh[WIDTH-1:0];
  assign dlo  = {lo_q[WIDTH-2:0], qbit};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    nlo     = '0;
    nhi     = '0;
    ovf     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = data_a;
          b_d   = data_b;
          cnt_d = '0;
          case (op)
            3'b101: begin
              hi_d    = '0;
              lo_d    = data_b;
              state_d = S_MUL;
            end
            3'b110: begin
              if (data_b != '0) begin
                hi_d    = '0;
                lo_d    = data_a;
                state_d = S_DIV;
              end else begin
                load    = 1'b1;
                nlo     = '1;
                nhi     = data_a;
                ovf     = 1'b1;
                state_d = S_FIN;
              end
            end
            default: begin
              load    = 1'b1;
              state_d = S_FIN;
              case (op)
                3'b000: begin
                  nlo = sum;
                  ovf = (data_a[WIDTH-1] == data_b[WIDTH-1]) && (sum[WIDTH-1] != data_a[WIDTH-1]);
                end
                3'b001: begin
                  nlo = diff;
                  ovf = (data_a[WIDTH-1] != data_b[WIDTH-1]) && (diff[WIDTH-1] != data_a[WIDTH-1]);
                end
                3'b010:  nlo = data_a & data_b;
                3'b011:  nlo = data_a | data_b;
                3'b100:  nlo = ~data_a;
                default: nlo = '0;
              endcase
            end
          endcase
        end
      end
      S_MUL: begin
        hi_d  = mhi;
        lo_d  = mlo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          load    = 1'b1;
          nhi     = mhi;
          nlo     = mlo;
          ovf     = (mhi != '0);
          state_d = S_FIN;
        end
      end
      S_DIV: begin
        hi_d  = dhi;
        lo_d  = dlo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          load    = 1'b1;
          nhi     = dhi;
          nlo     = dlo;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flag_q      <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      if (load) begin
        result_q    <= nlo;
        result_hi_q <= nhi;
        flag_q      <= {ovf, nlo[WIDTH-1], (nlo == '0)};
      end
    end
  end

  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign done      = (state_q == S_FIN);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag      = flag_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed bench for alu_multicycle against a plain-arithmetic reference model.
module tb_alu_multicycle;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        busy, done;
  logic [31:0] result, result_hi;
  logic [2:0]  flag;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  result8, result_hi8;
  logic [2:0]  flag8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  alu_multicycle #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .data_a(data_a), .data_b(data_b), .busy(busy), .done(done),
    .result(result), .result_hi(result_hi), .flag(flag)
  );

  alu_multicycle #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8),
    .data_a(a8), .data_b(b8), .busy(busy8), .done(done8),
    .result(result8), .result_hi(result_hi8), .flag(flag8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi, output logic [2:0] fl);
    longint s;
    logic [63:0] p;
    logic ov;
    lo = '0; hi = '0; ov = 1'b0;
    case (o)
      3'd0: begin s = longint'($signed(a)) + longint'($signed(b)); lo = s[31:0];
                  ov = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000); end
      3'd1: begin s = longint'($signed(a)) - longint'($signed(b)); lo = s[31:0];
                  ov = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000); end
      3'd2: lo = a & b;
      3'd3: lo = a | b;
      3'd4: lo = ~a;
      3'd5: begin p = {32'd0, a} * {32'd0, b}; lo = p[31:0]; hi = p[63:32]; ov = (hi != 0); end
      3'd6: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; ov = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: lo = '0;
    endcase
    fl = {ov, lo[31], lo == 0};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] el, eh, prev;
    logic [2:0]  ef;
    int cyc, nbusy, exp_lat;
    bit got, changed;
    string t;
    model(o, a, b, el, eh, ef);
    exp_lat = ((o == 3'd5) || (o == 3'd6 && b != 0)) ? 34 : 2;
    t = $sformatf("op%0d %0h,%0h", o, a, b);
    @(negedge clock);
    start = 1'b1; op = o; data_a = a; data_b = b;
    prev = result; cyc = 1; nbusy = 0; got = 0; changed = 0;
    while (!got && cyc < 100) begin
      @(negedge clock);
      start = 1'b0; op = 3'($urandom); data_a = $urandom; data_b = $urandom;
      cyc++;
      if (busy) nbusy++;
      if (done) got = 1;
      else if (result !== prev) changed = 1;
    end
    check({t, " done"}, 64'(got), 64'd1);
    check({t, " latency"}, 64'(cyc), 64'(exp_lat));
    check({t, " busy_cycles"}, 64'(nbusy), 64'(exp_lat - 2));
    check({t, " hold"}, 64'(changed), 64'd0);
    check({t, " result"}, 64'(result), 64'(el));
    check({t, " result_hi"}, 64'(result_hi), 64'(eh));
    check({t, " flag"}, 64'(flag), 64'(ef));
  endtask

  initial begin
    int cyc, ndone;
    logic [31:0] rb;

    #2;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst outs", {result, result_hi}, 64'd0);
    check("rst flag", 64'(flag), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_op(3'd0, 32'h7FFF_FFFF, 32'd1);
    run_op(3'd1, 32'd5, 32'd5);
    run_op(3'd4, 32'd0, 32'h1234_5678);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd5, 32'd6, 32'd7);
    run_op(3'd6, 32'd100, 32'd7);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd2, 32'hF0F0_FF00, 32'h0FF0_F0F0);
    run_op(3'd3, 32'hF000_0000, 32'h0000_000F);
    run_op(3'd7, 32'hDEAD_BEEF, 32'h1);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd1, 32'h8000_0000, 32'd1);

    // Reset in the middle of a multiply
    @(negedge clock);
    start = 1'b1; op = 3'd5; data_a = 32'd7; data_b = 32'd9;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst outs", {result, result_hi}, 64'd0);
    check("midrst flag", 64'(flag), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("midrst no_done", 64'(ndone), 64'd0);
    run_op(3'd0, 32'd1, 32'd2);

    // Start pulsed while a divide is busy must be ignored
    @(negedge clock);
    start = 1'b1; op = 3'd6; data_a = 32'd100; data_b = 32'd7;
    ndone = 0;
    for (cyc = 2; cyc <= 45; cyc++) begin
      @(negedge clock);
      start = (cyc == 5); op = 3'd0; data_a = 32'd1; data_b = 32'd2;
      if (done) ndone++;
    end
    check("busystart ndone", 64'(ndone), 64'd1);
    check("busystart result", 64'(result), 64'd14);
    check("busystart result_hi", 64'(result_hi), 64'd2);
    check("busystart flag", 64'(flag), 64'd0);

    for (int k = 0; k < 40; k++) begin
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      run_op(3'($urandom_range(0, 7)), $urandom, rb);
    end

    // Narrow build: 200*3
    @(negedge clock);
    start8 = 1'b1; op8 = 3'd5; a8 = 8'd200; b8 = 8'd3;
    cyc = 1;
    while (!done8 && cyc < 100) begin
      @(negedge clock);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      cyc++;
    end
    check("w8 latency", 64'(cyc), 64'd10);
    check("w8 result", 64'(result8), 64'h58);
    check("w8 result_hi", 64'(result_hi8), 64'h02);
    check("w8 flag", 64'(flag8), 64'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
